// File: rtl/dffsr_shreg_pkg.sv
// Shared types and limits for the dffsr_shreg register slice.
// Holds the mode encoding and the legal parameter bounds.
package dffsr_shreg_pkg;

  localparam int WIDTH_MAX      = 64;
  localparam int HIST_DEPTH_MAX = 16;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

endpackage

// File: rtl/dffsr_cell.sv
// One register bit with async reset and clear > set > next priority.
// Used WIDTH times by dffsr_shreg.
module dffsr_cell
  import dffsr_shreg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic set,
  input  logic nxt,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (set) q <= 1'b1;
    else          q <= nxt;
  end

endmodule

// File: rtl/dffsr_shreg.sv
// Shift/load register with per-bit sync set/clear and serial out.
// Define DFFSR_SHREG_HIST_EN to build the Q history pipeline.
module dffsr_shreg
  import dffsr_shreg_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HIST_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] SET,
  input  logic [WIDTH-1:0] CLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
`ifdef DFFSR_SHREG_HIST_EN
  output logic [WIDTH-1:0] Q_DLY,
  output logic             HIST_VALID,
`endif
  output logic             CONFLICT
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("dffsr_shreg: WIDTH out of range");
  end
  if (HIST_DEPTH < 1 || HIST_DEPTH > HIST_DEPTH_MAX) begin : g_bad_depth
    $error("dffsr_shreg: HIST_DEPTH out of range");
  end

  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] nxt;
  mode_e            mode;

  assign mode = mode_e'(MODE);

  // A 1-bit register simply takes SIN in either shift direction
  if (WIDTH == 1) begin : g_w1
    assign shl = SIN;
    assign shr = SIN;
  end else begin : g_wn
    assign shl = {Q[WIDTH-2:0], SIN};
    assign shr = {SIN, Q[WIDTH-1:1]};
  end

  always_comb begin
    nxt = Q;
    if (EN) begin
      unique case (mode)
        MODE_HOLD: nxt = Q;
        MODE_LOAD: nxt = D;
        MODE_SHL:  nxt = shl;
        MODE_SHR:  nxt = shr;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dffsr_cell u_cell (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (CLR[i]),
      .set   (SET[i]),
      .nxt   (nxt[i]),
      .q     (Q[i])
    );
  end

  // Shifted-out bit is taken from pre-edge Q, so set/clear cannot mask it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SOUT     <= 1'b0;
      CONFLICT <= 1'b0;
    end else begin
      CONFLICT <= |(SET & CLR);
      if (EN && mode == MODE_SHL)      SOUT <= Q[WIDTH-1];
      else if (EN && mode == MODE_SHR) SOUT <= Q[0];
    end
  end

`ifdef DFFSR_SHREG_HIST_EN
  logic [WIDTH-1:0] hist [HIST_DEPTH];
  logic [4:0]       fill;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int j = 0; j < HIST_DEPTH; j++) hist[j] <= '0;
      fill <= '0;
    end else begin
      hist[0] <= Q;
      for (int j = 1; j < HIST_DEPTH; j++) hist[j] <= hist[j-1];
      if (fill != 5'(HIST_DEPTH)) fill <= fill + 5'd1;
    end
  end

  assign Q_DLY      = hist[HIST_DEPTH-1];
  assign HIST_VALID = (fill == 5'(HIST_DEPTH));
`endif

endmodule

// File: tb/tb_dffsr_shreg.sv
// Directed bench for dffsr_shreg at WIDTH=8, HIST_DEPTH=4.
// History checks run only when DFFSR_SHREG_HIST_EN is defined.
module tb_dffsr_shreg;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] D, SET, CLR;
  logic       EN, SIN;
  logic [1:0] MODE;
  logic [7:0] Q;
  logic       SOUT, CONFLICT;
`ifdef DFFSR_SHREG_HIST_EN
  logic [7:0] Q_DLY;
  logic       HIST_VALID;
`endif

  int total = 0;
  int bad   = 0;

  dffsr_shreg #(.WIDTH(8), .HIST_DEPTH(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .D          (D),
    .SET        (SET),
    .CLR        (CLR),
    .EN         (EN),
    .MODE       (MODE),
    .SIN        (SIN),
    .Q          (Q),
    .SOUT       (SOUT),
`ifdef DFFSR_SHREG_HIST_EN
    .Q_DLY      (Q_DLY),
    .HIST_VALID (HIST_VALID),
`endif
    .CONFLICT   (CONFLICT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic en, input logic [1:0] m,
                     input logic [7:0] d, input logic s,
                     input logic [7:0] st, input logic [7:0] cl);
    EN = en; MODE = m; D = d; SIN = s; SET = st; CLR = cl;
  endtask

  initial begin
    RST_N = 1'b0;
    drv(0, 2'b00, 8'h00, 0, 8'h00, 8'h00);
    #2;
    chk("rst_q", Q, 8'h00);
    chk("rst_sout", SOUT, 1'b0);
    chk("rst_conf", CONFLICT, 1'b0);
    step();
    RST_N = 1'b1;

`ifdef DFFSR_SHREG_HIST_EN
    drv(1, 2'b01, 8'h11, 0, 8'h00, 8'h00); step();
    chk("hv_e1", HIST_VALID, 1'b0);
    drv(1, 2'b01, 8'h22, 0, 8'h00, 8'h00); step();
    chk("hv_e2", HIST_VALID, 1'b0);
    drv(1, 2'b01, 8'h33, 0, 8'h00, 8'h00); step();
    chk("hv_e3", HIST_VALID, 1'b0);
    drv(1, 2'b01, 8'h44, 0, 8'h00, 8'h00); step();
    chk("hv_e4", HIST_VALID, 1'b1);
    chk("qd_e4", Q_DLY, 8'h00);
    drv(1, 2'b01, 8'h55, 0, 8'h00, 8'h00); step();
    chk("hv_e5", HIST_VALID, 1'b1);
    chk("qd_e5", Q_DLY, 8'h11);
    chk("q_e5", Q, 8'h55);
`endif

    // async reset: reach Q=A5, SOUT=1 first
    drv(1, 2'b01, 8'h80, 0, 8'h00, 8'h00); step();
    drv(1, 2'b10, 8'h00, 0, 8'h00, 8'h00); step();
    chk("pre_shl_q", Q, 8'h00);
    drv(1, 2'b01, 8'hA5, 0, 8'h00, 8'h00); step();
    chk("pre_rst_q", Q, 8'hA5);
    chk("pre_rst_sout", SOUT, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_q", Q, 8'h00);
    chk("arst_sout", SOUT, 1'b0);
    RST_N = 1'b1;

    // load then shift
    drv(1, 2'b01, 8'h81, 0, 8'h00, 8'h00); step();
    chk("load_q", Q, 8'h81);
    drv(1, 2'b10, 8'h00, 1, 8'h00, 8'h00); step();
    chk("shl_q", Q, 8'h03);
    chk("shl_sout", SOUT, 1'b1);
    drv(1, 2'b11, 8'h00, 0, 8'h00, 8'h00); step();
    chk("shr_q", Q, 8'h01);
    chk("shr_sout", SOUT, 1'b1);
    drv(1, 2'b00, 8'hFF, 1, 8'h00, 8'h00); step();
    chk("hold_q", Q, 8'h01);
    drv(0, 2'b01, 8'hFF, 1, 8'h00, 8'h00); step();
    chk("en0_q", Q, 8'h01);
    chk("en0_sout", SOUT, 1'b1);

    // priority: clear, then set+clear together
    drv(0, 2'b00, 8'h00, 0, 8'h00, 8'hFF); step();
    chk("clr_q", Q, 8'h00);
    drv(0, 2'b00, 8'h00, 0, 8'hFF, 8'h0F); step();
    chk("prio_q", Q, 8'hF0);
    chk("prio_conf", CONFLICT, 1'b1);
    drv(0, 2'b00, 8'h00, 0, 8'h00, 8'h00); step();
    chk("prio2_q", Q, 8'hF0);
    chk("prio2_conf", CONFLICT, 1'b0);

    // set wins over load when enabled
    drv(1, 2'b01, 8'h00, 0, 8'h0C, 8'h00); step();
    chk("set_en_q", Q, 8'h0C);

    // override during shift; first force SOUT to 0
    drv(1, 2'b01, 8'h80, 0, 8'h00, 8'h00); step();
    drv(1, 2'b11, 8'h00, 0, 8'h00, 8'h00); step();
    chk("shr0_q", Q, 8'h40);
    chk("shr0_sout", SOUT, 1'b0);
    drv(1, 2'b01, 8'h80, 0, 8'h00, 8'h00); step();
    drv(1, 2'b10, 8'h00, 1, 8'h00, 8'h01); step();
    chk("ovr_q", Q, 8'h00);
    chk("ovr_sout", SOUT, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dffsr_shreg.md
DFFSR_SHREG -- requirements
Module: dffsr_shreg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 1..64.
REQ-002 Parameter HIST_DEPTH, default 4: history delay in cycles; legal range 1..16; used only with DFFSR_SHREG_HIST_EN.
REQ-003 Port CLK  in  1: rising-edge clock.
REQ-004 Port RST_N  in  1: reset. Reset is asynchronous and active-low.
REQ-005 Port D  in  WIDTH: parallel load data.
REQ-006 Port SET  in  WIDTH: per-bit synchronous set.
REQ-007 Port CLR  in  WIDTH: per-bit synchronous clear.
REQ-008 Port EN  in  1: enables the MODE operation.
REQ-009 Port MODE  in  2: operation select. 00 = hold, 01 = load, 10 = shift left, 11 = shift right.
REQ-010 Port SIN  in  1: serial input.
REQ-011 Port Q  out  WIDTH: register state.
REQ-012 Port SOUT  out  1: last bit shifted out, registered.
REQ-013 Port CONFLICT  out  1: registered flag; at least one bit had SET and CLR high together in the previous cycle.
REQ-014 Port Q_DLY  out  WIDTH: Q delayed by HIST_DEPTH cycles; present only with DFFSR_SHREG_HIST_EN.
REQ-015 Port HIST_VALID  out  1: Q_DLY is meaningful; present only with DFFSR_SHREG_HIST_EN.

Function
REQ-016 Each bit i SHALL be updated at every CLK rising edge with this priority: CLR[i] gives 0; else SET[i] gives 1; else if EN, the MODE result; else hold.
REQ-017 SET and CLR SHALL act regardless of EN and MODE.
REQ-018 MODE results SHALL be:
- 00: Q unchanged.
- 01: D.
- 10: {Q[WIDTH-2:0], SIN}.
- 11: {SIN, Q[WIDTH-1:1]}.
REQ-019 For WIDTH=1, both shift modes SHALL load SIN.
REQ-020 SOUT update rules:
- EN=1, MODE=10: SOUT takes the pre-edge Q[WIDTH-1].
- EN=1, MODE=11: SOUT takes the pre-edge Q[0].
- Otherwise: SOUT holds.
- SET/CLR never affect SOUT.
REQ-021 SOUT SHALL capture the shifted-out bit even if SET or CLR overrides the destination bit in the same cycle.
REQ-022 CONFLICT SHALL take |(SET & CLR) at every edge.
REQ-023 Latency: every output SHALL change only at a CLK edge (or on reset) and SHALL reflect inputs sampled at that edge. There is no combinational path from any input to any output.

Reset
REQ-024 While RST_N=0, the following SHALL be 0 immediately, independent of CLK:
- Q, SOUT, CONFLICT;
- all history stages, Q_DLY, HIST_VALID, and the fill counter.
REQ-025 Reset asserted mid-operation SHALL abort the operation. The first edge with RST_N=1 SHALL apply REQ-016 normally.

Configuration
REQ-026 Macro DFFSR_SHREG_HIST_EN defined: a HIST_DEPTH-stage history pipeline of Q SHALL be built.
- After edge k, Q_DLY equals Q after edge k-HIST_DEPTH.
- A saturating counter SHALL assert HIST_VALID from the HIST_DEPTH-th edge after reset release onward.
REQ-027 Macro undefined: Q_DLY, HIST_VALID and all history logic SHALL be absent. Core behaviour SHALL be identical.

Structure
REQ-028 Package dffsr_shreg_pkg SHALL hold:
- typedef mode_e (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR);
- constants WIDTH_MAX=64 and HIST_DEPTH_MAX=16.
REQ-029 Sub-module dffsr_cell SHALL implement one bit: async reset, CLR>SET>next-value priority, inputs nxt and clr/set. dffsr_shreg SHALL instantiate WIDTH cells.
REQ-030 Parameter range violations SHALL be rejected at elaboration.

Verification (WIDTH=8, HIST_DEPTH=4)
REQ-031 Async reset: Q=0xA5, SOUT=1; drop RST_N between edges -> Q=0x00 and SOUT=0 before the next edge.
REQ-032 Load then shift: EN=1, MODE=01, D=0x81 -> Q=0x81. Next MODE=10, SIN=1 -> Q=0x03, SOUT=1. Next MODE=11, SIN=0 -> Q=0x01, SOUT=1.
REQ-033 Priority: Q=0x00, EN=0, SET=0xFF, CLR=0x0F -> Q=0xF0, CONFLICT=1. Next edge with SET=CLR=0 -> Q=0xF0, CONFLICT=0.
REQ-034 Override during shift: Q=0x80, EN=1, MODE=10, SIN=1, CLR=0x01 -> Q=0x00, SOUT=1.
REQ-035 History (macro defined): after reset, load 0x11, 0x22, 0x33, 0x44, 0x55 on edges 1..5 ->
- HIST_VALID=0 after edges 1..3, 1 from edge 4;
- Q_DLY=0x00 after edge 4, 0x11 after edge 5.
REQ-036 Build without macro: repeat REQ-032..034 -> identical results; Q_DLY and HIST_VALID ports absent.
